// File: rtl/matmul_core.sv
// Hardwired matrix-multiply core: D = A x B over a single-port data memory.
// Several instances can split one job by rows, selected by CORE_ID/NUM_CORES.
module matmul_core #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DIM_W     = 8,
    parameter int NUM_CORES = 1,
    parameter int CORE_ID   = 0,
    parameter int SAT       = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        status,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [DIM_W-1:0]  dim_j,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    output logic [ADDR_W-1:0] addr_data_0,
    output logic              write_en0,
    output logic [DATA_W-1:0] datain0,
    input  logic [DATA_W-1:0] dataout0,
    output logic              end_process,
    output logic              busy,
    output logic              overflow
);

    localparam int ACC_W = 2 * DATA_W + DIM_W;
    localparam int PW    = 2 * DIM_W + ADDR_W;
    localparam logic             SAT_EN    = (SAT != 32'sd0);
    localparam logic [DIM_W:0]   CORE_ID_W = (DIM_W + 1)'(CORE_ID);
    localparam logic [DIM_W:0]   NC_W      = (DIM_W + 1)'(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_MAC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d, state_n_s;
    logic [DIM_W-1:0]    dim_i_q, dim_i_d, dim_j_q, dim_j_d, dim_k_q, dim_k_d;
    logic [ADDR_W-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_d_q, base_d_d;
    logic [DIM_W-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                overflow_q, overflow_d;

    logic [PW-1:0]       addr_a_s, addr_b_s, addr_d_s;
    logic [DIM_W:0]      i_next_s;
    logic                k_last_s, j_last_s, ovf_s, abort_s, zero_job_s;

    // Address arithmetic is done wide and then truncated so sums wrap modulo 2^ADDR_W.
    always_comb begin
        addr_a_s   = PW'(base_a_q) + PW'(i_q) * PW'(dim_k_q) + PW'(k_q);
        addr_b_s   = PW'(base_b_q) + PW'(k_q) * PW'(dim_j_q) + PW'(j_q);
        addr_d_s   = PW'(base_d_q) + PW'(i_q) * PW'(dim_j_q) + PW'(j_q);
        i_next_s   = {1'b0, i_q} + NC_W;
        k_last_s   = ({1'b0, k_q} + (DIM_W + 1)'(1)) >= {1'b0, dim_k_q};
        j_last_s   = ({1'b0, j_q} + (DIM_W + 1)'(1)) >= {1'b0, dim_j_q};
        ovf_s      = |acc_q[ACC_W-1:DATA_W];
        abort_s    = (status == 2'b11) &&
                     ((state_q == S_RD_A) || (state_q == S_RD_B) ||
                      (state_q == S_MAC)  || (state_q == S_WRITE));
        zero_job_s = (dim_i == '0) || (dim_j == '0) || (dim_k == '0) ||
                     (CORE_ID_W >= {1'b0, dim_i});
    end

    // Next-state and datapath update.
    always_comb begin
        state_n_s  = state_q;
        dim_i_d    = dim_i_q;
        dim_j_d    = dim_j_q;
        dim_k_d    = dim_k_q;
        base_a_d   = base_a_q;
        base_b_d   = base_b_q;
        base_d_d   = base_d_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        a_d        = a_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (status == 2'b01) begin
                    dim_i_d    = dim_i;
                    dim_j_d    = dim_j;
                    dim_k_d    = dim_k;
                    base_a_d   = base_a;
                    base_b_d   = base_b;
                    base_d_d   = base_d;
                    overflow_d = 1'b0;
                    i_d        = CORE_ID_W[DIM_W-1:0];
                    j_d        = '0;
                    k_d        = '0;
                    acc_d      = '0;
                    state_n_s  = zero_job_s ? S_DONE : S_RD_A;
                end else begin
                    state_n_s  = S_IDLE;
                end
            end
            S_RD_A: state_n_s = S_RD_B;
            S_RD_B: begin
                a_d       = dataout0;
                state_n_s = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(a_q) * ACC_W'(dataout0);
                if (k_last_s) begin
                    k_d       = '0;
                    state_n_s = S_WRITE;
                end else begin
                    k_d       = k_q + DIM_W'(1);
                    state_n_s = S_RD_A;
                end
            end
            S_WRITE: begin
                // The write itself is Moore-decoded, so an abort here still completes it.
                overflow_d = overflow_q | ovf_s;
                acc_d      = '0;
                if (!j_last_s) begin
                    j_d       = j_q + DIM_W'(1);
                    state_n_s = S_RD_A;
                end else begin
                    j_d       = '0;
                    i_d       = i_next_s[DIM_W-1:0];
                    state_n_s = (i_next_s >= {1'b0, dim_i_q}) ? S_DONE : S_RD_A;
                end
            end
            S_DONE: state_n_s = (status == 2'b00) ? S_IDLE : S_DONE;
            default: state_n_s = S_IDLE;
        endcase
        state_d = abort_s ? S_IDLE : state_n_s;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dim_i_q    <= '0;
            dim_j_q    <= '0;
            dim_k_q    <= '0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_d_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dim_i_q    <= dim_i_d;
            dim_j_q    <= dim_j_d;
            dim_k_q    <= dim_k_d;
            base_a_q   <= base_a_d;
            base_b_q   <= base_b_d;
            base_d_q   <= base_d_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        addr_data_0 = '0;
        write_en0   = 1'b0;
        datain0     = '0;
        end_process = (state_q == S_DONE);
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        overflow    = overflow_q;
        case (state_q)
            S_RD_A:  addr_data_0 = addr_a_s[ADDR_W-1:0];
            S_RD_B:  addr_data_0 = addr_b_s[ADDR_W-1:0];
            S_WRITE: begin
                addr_data_0 = addr_d_s[ADDR_W-1:0];
                write_en0   = 1'b1;
                datain0     = (SAT_EN && ovf_s) ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
            end
            default: addr_data_0 = '0;
        endcase
    end

endmodule

// File: tb/tb_matmul_core.sv
// Scoreboard bench for matmul_core: four instances (SAT on/off, two-core split)
// share a behavioural single-port memory; expected writes are queued and checked by a monitor.
module tb_matmul_core;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  st [4];
    logic [7:0]  di, dj, dk, ba, bb, bd;
    logic [7:0]  addr_w [4];
    logic        we_w [4];
    logic [15:0] din_w [4];
    logic [15:0] dout_w [4];
    logic        ep_w [4];
    logic        busy_w [4];
    logic        ovf_w [4];

    logic [15:0] mem [256];
    logic        ld_en;
    logic [7:0]  ld_a;
    logic [15:0] ld_d;

    int          total = 0;
    int          bad   = 0;
    logic [25:0] exp_q [$];

    always #5 clock = ~clock;

    matmul_core #(.DATA_W(16), .ADDR_W(8), .DIM_W(8), .NUM_CORES(1), .CORE_ID(0), .SAT(1)) u0 (
        .clock(clock), .reset_n(reset_n), .status(st[0]),
        .dim_i(di), .dim_j(dj), .dim_k(dk), .base_a(ba), .base_b(bb), .base_d(bd),
        .addr_data_0(addr_w[0]), .write_en0(we_w[0]), .datain0(din_w[0]), .dataout0(dout_w[0]),
        .end_process(ep_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0]));
    matmul_core #(.DATA_W(16), .ADDR_W(8), .DIM_W(8), .NUM_CORES(1), .CORE_ID(0), .SAT(0)) u1 (
        .clock(clock), .reset_n(reset_n), .status(st[1]),
        .dim_i(di), .dim_j(dj), .dim_k(dk), .base_a(ba), .base_b(bb), .base_d(bd),
        .addr_data_0(addr_w[1]), .write_en0(we_w[1]), .datain0(din_w[1]), .dataout0(dout_w[1]),
        .end_process(ep_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1]));
    matmul_core #(.DATA_W(16), .ADDR_W(8), .DIM_W(8), .NUM_CORES(2), .CORE_ID(0), .SAT(1)) u2 (
        .clock(clock), .reset_n(reset_n), .status(st[2]),
        .dim_i(di), .dim_j(dj), .dim_k(dk), .base_a(ba), .base_b(bb), .base_d(bd),
        .addr_data_0(addr_w[2]), .write_en0(we_w[2]), .datain0(din_w[2]), .dataout0(dout_w[2]),
        .end_process(ep_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2]));
    matmul_core #(.DATA_W(16), .ADDR_W(8), .DIM_W(8), .NUM_CORES(2), .CORE_ID(1), .SAT(1)) u3 (
        .clock(clock), .reset_n(reset_n), .status(st[3]),
        .dim_i(di), .dim_j(dj), .dim_k(dk), .base_a(ba), .base_b(bb), .base_d(bd),
        .addr_data_0(addr_w[3]), .write_en0(we_w[3]), .datain0(din_w[3]), .dataout0(dout_w[3]),
        .end_process(ep_w[3]), .busy(busy_w[3]), .overflow(ovf_w[3]));

    // Memory: one registered read port per instance, writes from instances and bench loader.
    always @(posedge clock) begin
        for (int n = 0; n < 4; n++) dout_w[n] <= mem[addr_w[n]];
        if (ld_en) mem[ld_a] <= ld_d;
        for (int n = 0; n < 4; n++) if (we_w[n] === 1'b1) mem[addr_w[n]] <= din_w[n];
    end

    // Monitor: every observed write strobe must match the head of the expected queue.
    initial begin
        logic [25:0] got;
        logic [25:0] want;
        forever begin
            @(negedge clock);
            for (int n = 0; n < 4; n++) begin
                if (we_w[n] === 1'b1) begin
                    got = {2'(n), addr_w[n], din_w[n]};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL write_unexpected got(inst,addr,data)=%h required=none", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL write_seq got(inst,addr,data)=%h required=%h", got, want);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_job(input logic [7:0] i, j, k, a, b, d);
        di = i; dj = j; dk = k; ba = a; bb = b; bd = d;
    endtask

    task automatic push(input int n, input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back({2'(n), a, d});
    endtask

    // Start instance n, measure edges after the start-sampling edge until end_process, then release.
    task automatic run_job(input int n, input int exp_lat, input logic exp_ovf, input string nm);
        int lat;
        st[n] = 2'b01;
        tick();
        lat = 0;
        while (ep_w[n] !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_overflow"}, {31'd0, ovf_w[n]}, {31'd0, exp_ovf});
        tick();
        tick();
        chk({nm, "_done_held"}, {30'd0, ep_w[n], busy_w[n]}, 32'd2);
        st[n] = 2'b00;
        tick();
        chk({nm, "_released"}, {30'd0, ep_w[n], busy_w[n]}, 32'd0);
    endtask

    initial begin
        logic [15:0] dexp [6];
        int l2, l3, ep_seen, lat;
        dexp = '{16'd19, 16'd22, 16'd43, 16'd50, 16'd67, 16'd78};
        reset_n = 1'b0;
        ld_en = 1'b0; ld_a = 8'd0; ld_d = 16'd0;
        for (int n = 0; n < 4; n++) st[n] = 2'b00;
        set_job(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        #12;
        for (int n = 0; n < 4; n++)
            chk($sformatf("reset_outputs_u%0d", n),
                {4'd0, addr_w[n], we_w[n], din_w[n], ep_w[n], busy_w[n], ovf_w[n]}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 2x2x2 basic job
        poke(8'h10, 16'd1); poke(8'h11, 16'd2); poke(8'h12, 16'd3); poke(8'h13, 16'd4);
        poke(8'h20, 16'd5); poke(8'h21, 16'd6); poke(8'h22, 16'd7); poke(8'h23, 16'd8);
        set_job(8'd2, 8'd2, 8'd2, 8'h10, 8'h20, 8'h30);
        push(0, 8'h30, 16'd19); push(0, 8'h31, 16'd22); push(0, 8'h32, 16'd43); push(0, 8'h33, 16'd50);
        run_job(0, 28, 1'b0, "mm2x2");

        // 1x1x1 overflow: saturate vs truncate
        poke(8'h40, 16'd300); poke(8'h41, 16'd300);
        set_job(8'd1, 8'd1, 8'd1, 8'h40, 8'h41, 8'h42);
        push(0, 8'h42, 16'hFFFF);
        run_job(0, 4, 1'b1, "sat");
        push(1, 8'h42, 16'd24464);
        run_job(1, 4, 1'b1, "trunc");

        // dim_k = 0: no memory writes, done right after the sampling edge, overflow cleared
        set_job(8'd2, 8'd2, 8'd0, 8'h10, 8'h20, 8'h30);
        run_job(0, 0, 1'b0, "zero_k");

        // Two cores splitting a 3x2x2 job
        poke(8'h50, 16'd1); poke(8'h51, 16'd2); poke(8'h52, 16'd3);
        poke(8'h53, 16'd4); poke(8'h54, 16'd5); poke(8'h55, 16'd6);
        poke(8'h60, 16'd5); poke(8'h61, 16'd6); poke(8'h62, 16'd7); poke(8'h63, 16'd8);
        for (int a = 0; a < 6; a++) poke(8'h70 + 8'(a), 16'd0);
        set_job(8'd3, 8'd2, 8'd2, 8'h50, 8'h60, 8'h70);
        push(2, 8'h70, 16'd19); push(3, 8'h72, 16'd43);
        push(2, 8'h71, 16'd22); push(3, 8'h73, 16'd50);
        push(2, 8'h74, 16'd67); push(2, 8'h75, 16'd78);
        st[2] = 2'b01; st[3] = 2'b01;
        tick();
        l2 = -1; l3 = -1;
        for (int c = 0; c < 100; c++) begin
            if (ep_w[2] === 1'b1 && l2 < 0) l2 = c;
            if (ep_w[3] === 1'b1 && l3 < 0) l3 = c;
            if (l2 >= 0 && l3 >= 0) break;
            tick();
        end
        chk("split_core0_latency", 32'(l2), 32'd28);
        chk("split_core1_latency", 32'(l3), 32'd14);
        st[2] = 2'b00; st[3] = 2'b00;
        tick();
        for (int a = 0; a < 6; a++)
            chk($sformatf("split_merged_d%0d", a), {16'd0, mem[8'h70 + 8'(a)]}, {16'd0, dexp[a]});

        // Abort during MAC of the first element
        set_job(8'd2, 8'd2, 8'd2, 8'h10, 8'h20, 8'h30);
        st[0] = 2'b01;
        tick(); tick(); tick();
        chk("abort_pre_busy", {31'd0, busy_w[0]}, 32'd1);
        st[0] = 2'b11;
        tick();
        chk("abort_idle", {30'd0, ep_w[0], busy_w[0]}, 32'd0);
        st[0] = 2'b00;
        ep_seen = 0;
        repeat (40) begin
            tick();
            if (ep_w[0] !== 1'b0) ep_seen++;
        end
        chk("abort_no_end", 32'(ep_seen), 32'd0);

        // Reset asserted during WRITE, then a clean restart
        st[0] = 2'b01;
        tick();
        repeat (6) tick();
        chk("rst_in_write", {31'd0, we_w[0]}, 32'd1);
        reset_n = 1'b0;
        st[0] = 2'b00;
        #1;
        chk("rst_async_clear", {4'd0, addr_w[0], we_w[0], din_w[0], ep_w[0], busy_w[0], ovf_w[0]}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        push(0, 8'h30, 16'd19); push(0, 8'h31, 16'd22); push(0, 8'h32, 16'd43); push(0, 8'h33, 16'd50);
        run_job(0, 28, 1'b0, "restart");

        // Address wrap: A row spans 0xFF..0x00, D lands at 0xFE..0xFF
        poke(8'hFF, 16'd2); poke(8'h00, 16'd3);
        poke(8'h80, 16'd5); poke(8'h81, 16'd6); poke(8'h82, 16'd7); poke(8'h83, 16'd8);
        set_job(8'd1, 8'd2, 8'd2, 8'hFF, 8'h80, 8'hFE);
        push(0, 8'hFE, 16'd31); push(0, 8'hFF, 16'd36);
        st[0] = 2'b01;
        tick();
        chk("wrap_read_a0", {24'd0, addr_w[0]}, 32'hFF);
        tick(); tick(); tick();
        chk("wrap_read_a1", {24'd0, addr_w[0]}, 32'h00);
        lat = 3;
        while (ep_w[0] !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        chk("wrap_latency", 32'(lat), 32'd14);
        st[0] = 2'b00;
        tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1);
    end

endmodule
